// File: rtl/lane_traffic_pkg.sv
// Shared defaults and helpers for the frog-game lane traffic generator.
// Geometry defaults match color_generation and player_control.
package lane_traffic_pkg;

  localparam int DEF_X_W      = 10;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_LEVEL_W  = 3;
  localparam int DEF_LANE_Y0  = 80;
  localparam int DEF_LANE_H   = 40;
  localparam int DEF_CAR_W    = 32;
  localparam int DEF_PLAYER_W = 16;
  localparam int HIT_LANE_W   = 4;

  typedef logic [HIT_LANE_W-1:0] lane_idx_t;

  // Ticks per 1-px step; signed arithmetic so a high level clamps instead of wrapping.
  function automatic int lane_period(input int base_period, input int lane, input int level);
    int p;
    p = base_period + (lane % 4) - level;
    return (p < 1) ? 1 : p;
  endfunction

endpackage

// File: rtl/lane_mover.sv
// One car lane: step counter, level-scaled period, wrapping x position, player overlap test.
// Position updates on the edge ending a tick cycle; overlap is combinational. Optional: LANE_TRAFFIC_COLLIDE_EN.
module lane_mover
  import lane_traffic_pkg::*;
#(
  parameter int LANE        = 0,
  parameter int DIR         = 0,
  parameter int RST_X       = 0,
  parameter int X_W         = DEF_X_W,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int BASE_PERIOD = 6,
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int LANE_Y0     = DEF_LANE_Y0,
  parameter int LANE_H      = DEF_LANE_H,
  parameter int CAR_W       = DEF_CAR_W,
  parameter int PLAYER_W    = DEF_PLAYER_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  input  logic [LEVEL_W-1:0] level_i,
  input  logic [X_W-1:0]     player_x_i,
  input  logic [X_W-1:0]     player_y_i,
  output logic [X_W-1:0]     car_x_o,
  output logic               overlap_o
);

  localparam int CNT_W = $clog2(BASE_PERIOD + 4);

  logic [CNT_W-1:0] cnt_q, cnt_d, per_m1;
  logic [X_W-1:0]   x_q, x_d;

  always_comb begin
    per_m1 = CNT_W'(lane_period(BASE_PERIOD, LANE, int'(level_i)) - 1);
    cnt_d  = cnt_q;
    x_d    = x_q;
    if (tick_i) begin
      // ">=" lets a counter stranded above a shortened period step at once.
      if (cnt_q >= per_m1) begin
        cnt_d = '0;
        if (DIR == 0) begin
          x_d = (x_q == X_W'(SCREEN_W - 1)) ? '0 : x_q + X_W'(1);
        end else begin
          x_d = (x_q == '0) ? X_W'(SCREEN_W - 1) : x_q - X_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      x_q   <= X_W'(RST_X);
    end else begin
      cnt_q <= cnt_d;
      x_q   <= x_d;
    end
  end

  assign car_x_o = x_q;

`ifdef LANE_TRAFFIC_COLLIDE_EN
  localparam int Y_LO = LANE_Y0 + LANE * LANE_H;
  localparam int Y_HI = Y_LO + LANE_H;

  logic         in_row;
  logic [X_W:0] p_left, p_right, c_left, c_right;

  always_comb begin
    in_row    = (32'(player_y_i) >= 32'(Y_LO)) && (32'(player_y_i) < 32'(Y_HI));
    p_left    = {1'b0, player_x_i};
    p_right   = p_left + (X_W+1)'(PLAYER_W);
    c_left    = {1'b0, x_q};
    c_right   = c_left + (X_W+1)'(CAR_W);
    overlap_o = in_row && (p_right > c_left) && (p_left < c_right);
  end
`else
  localparam int unused_geom = LANE_Y0 + LANE_H + CAR_W + PLAYER_W;
  wire unused_player = ^{player_x_i, player_y_i};
  assign overlap_o = 1'b0;
`endif

endmodule

// File: rtl/lane_traffic.sv
// Frog-game traffic: prescaler, N_LANES lane_movers, sticky lowest-index hit. Optional: LANE_TRAFFIC_COLLIDE_EN.
// All outputs registered; car_x moves 1 cycle after tick, hit 1 cycle after overlap; no backpressure.
module lane_traffic
  import lane_traffic_pkg::*;
#(
  parameter int N_LANES     = 8,
  parameter int X_W         = DEF_X_W,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int TICK_DIV    = 250000,
  parameter int BASE_PERIOD = 6,
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int STAGGER     = 80,
  parameter int LANE_Y0     = DEF_LANE_Y0,
  parameter int LANE_H      = DEF_LANE_H,
  parameter int CAR_W       = DEF_CAR_W,
  parameter int PLAYER_W    = DEF_PLAYER_W
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   pause,
  input  logic [LEVEL_W-1:0]     level,
  input  logic [X_W-1:0]         player_x,
  input  logic [X_W-1:0]         player_y,
  input  logic                   hit_clr,
  output logic [N_LANES*X_W-1:0] car_x,
  output logic                   tick,
  output logic                   hit,
  output logic [HIT_LANE_W-1:0]  hit_lane
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0]   presc_q, presc_d;
  logic               tick_q, tick_d;
  logic [N_LANES-1:0] ovl;

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (!pause) begin
      if (presc_q == PRE_W'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    lane_mover #(
      .LANE        (gi),
      .DIR         (gi % 2),
      .RST_X       ((gi * STAGGER) % SCREEN_W),
      .X_W         (X_W),
      .SCREEN_W    (SCREEN_W),
      .BASE_PERIOD (BASE_PERIOD),
      .LEVEL_W     (LEVEL_W),
      .LANE_Y0     (LANE_Y0),
      .LANE_H      (LANE_H),
      .CAR_W       (CAR_W),
      .PLAYER_W    (PLAYER_W)
    ) u_lane (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .tick_i     (tick_q),
      .level_i    (level),
      .player_x_i (player_x),
      .player_y_i (player_y),
      .car_x_o    (car_x[gi*X_W +: X_W]),
      .overlap_o  (ovl[gi])
    );
  end

`ifdef LANE_TRAFFIC_COLLIDE_EN
  logic      hit_q, hit_d;
  lane_idx_t hit_lane_q, hit_lane_d, first;

  always_comb begin
    first = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (ovl[i]) first = lane_idx_t'(i);
    end
    hit_d      = hit_q;
    hit_lane_d = hit_lane_q;
    // A fresh overlap beats a simultaneous clear and re-records the lane.
    if ((|ovl) && (!hit_q || hit_clr)) begin
      hit_d      = 1'b1;
      hit_lane_d = first;
    end else if (hit_clr) begin
      hit_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      hit_q      <= 1'b0;
      hit_lane_q <= '0;
    end else begin
      hit_q      <= hit_d;
      hit_lane_q <= hit_lane_d;
    end
  end

  assign hit      = hit_q;
  assign hit_lane = hit_lane_q;
`else
  wire unused_hit = ^{hit_clr, ovl};
  assign hit      = 1'b0;
  assign hit_lane = '0;
`endif

endmodule

// File: tb/tb_lane_traffic.sv
// Directed bench for lane_traffic: expectations are queued with a target cycle, a monitor compares them.
module tb_lane_traffic;

  localparam int NL = 8;
  localparam int XW = 10;
`ifdef LANE_TRAFFIC_COLLIDE_EN
  localparam int COLL = 1;
`else
  localparam int COLL = 0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N, pause, hit_clr;
  logic [2:0]    level;
  logic [XW-1:0] player_x, player_y;
  logic [NL*XW-1:0] car_x;
  logic          tick, hit;
  logic [3:0]    hit_lane;

  always #5 CLK = ~CLK;

  lane_traffic #(
    .N_LANES(NL), .X_W(XW), .SCREEN_W(640), .TICK_DIV(4), .BASE_PERIOD(2),
    .LEVEL_W(3), .STAGGER(80), .LANE_Y0(80), .LANE_H(40), .CAR_W(32), .PLAYER_W(16)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .pause(pause), .level(level),
    .player_x(player_x), .player_y(player_y), .hit_clr(hit_clr),
    .car_x(car_x), .tick(tick), .hit(hit), .hit_lane(hit_lane)
  );

  typedef struct {
    int    cyc;
    int    fld;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  localparam int F_TICK = 8;
  localparam int F_HIT  = 9;
  localparam int F_LANE = 10;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int dut_val(input int f);
    if (f < NL) return int'(car_x[f*XW +: XW]);
    if (f == F_TICK) return int'(tick);
    if (f == F_HIT) return int'(hit);
    return int'(hit_lane);
  endfunction

  task automatic expect_at(input int c, input int f, input int v, input string n);
    exp_t e;
    e.cyc = c; e.fld = f; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic expect_lanes(input int c, input int v[NL], input string n);
    for (int i = 0; i < NL; i++) expect_at(c, i, v[i], $sformatf("%s_x%0d", n, i));
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  // Monitor: compares every queued expectation whose target cycle has arrived.
  initial begin
    forever begin
      @(negedge CLK);
      for (int i = 0; i < q.size(); ) begin
        if (q[i].cyc <= cyc) begin
          int a;
          a = dut_val(q[i].fld);
          checks++;
          if (q[i].cyc != cyc || a != q[i].val) begin
            errors++;
            $display("FAIL %s at cycle %0d (due %0d): got %0d expected %0d",
                     q[i].name, cyc, q[i].cyc, a, q[i].val);
          end
          q.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  initial begin
    int v[NL];
    int rst_x[NL];
    int base;
    int guard;
    rst_x = '{0, 80, 160, 240, 320, 400, 480, 560};
    RST_N = 1'b0; pause = 1'b0; hit_clr = 1'b0; level = 3'd0;
    player_x = '0; player_y = '0;
    @(negedge CLK);

    // Reset overrides pause and hit_clr.
    wait_to(3);
    pause = 1'b1; hit_clr = 1'b1;
    expect_lanes(4, rst_x, "rst");
    expect_at(4, F_TICK, 0, "rst_tick");
    expect_at(4, F_HIT,  0, "rst_hit");
    expect_at(4, F_LANE, 0, "rst_hit_lane");

    wait_to(5);
    base = 5;
    RST_N = 1'b1; pause = 1'b0; hit_clr = 1'b0;
    expect_at(base+3,  F_TICK, 0,  "tick_before_first");
    expect_at(base+4,  F_TICK, 1,  "first_tick");
    expect_at(base+8,  0, 0,  "l0_hold_1tick");
    expect_at(base+9,  0, 1,  "l0_step_2ticks");
    expect_at(base+12, 1, 80, "l1_hold_2ticks");
    expect_at(base+13, 1, 79, "l1_step_3ticks");
    v = '{6, 76, 163, 238, 326, 396, 483, 558};
    expect_lanes(base+49, v, "k12");

    // Pause for 20 cycles, prescaler at 2.
    wait_to(base+50);
    pause = 1'b1;
    expect_at(base+52, F_TICK, 0,   "pause_no_tick");
    expect_at(base+60, 0, 6,        "pause_l0_frozen");
    expect_at(base+69, 3, 238,      "pause_l3_frozen");
    expect_at(base+71, F_TICK, 0,   "resume_tick_low");
    expect_at(base+72, F_TICK, 1,   "resume_tick");
    expect_at(base+76, 0, 6,        "resume_l0_hold");
    expect_at(base+77, 0, 7,        "resume_l0_step");
    wait_to(base+70);
    pause = 1'b0;

    // Lane 1 wraps 0 -> 639 on tick 243.
    expect_at(base+992, 1, 0, "l1_at_zero");
    v = '{121, 639, 220, 192, 441, 319, 540, 512};
    expect_lanes(base+993, v, "k243");

    // Level 7 clamps every period to 1.
    wait_to(base+994);
    level = 3'd7;
    v = '{122, 638, 221, 191, 442, 318, 541, 511};
    expect_lanes(base+997, v, "lvl7");
    expect_at(base+1001, 0, 123, "lvl7_l0_next");
    expect_at(base+3065, 0, 639, "l0_at_639");
    expect_at(base+3069, 0, 0,   "l0_wrap_0");
    expect_at(base+3069, 1, 120, "l1_lvl7");
    expect_at(base+3069, 2, 99,  "l2_wrap");

    // Collision: lane 0 car at 90, player at (100,85).
    wait_to(base+3428);
    expect_at(base+3429, F_HIT, 0, "hit_before");
    expect_at(base+3429, 0, 90,    "l0_at_90");
    wait_to(base+3429);
    player_x = 10'd100; player_y = 10'd85;
    expect_at(base+3430, F_HIT,  COLL, "hit_lane0");
    expect_at(base+3430, F_LANE, 0,    "hit_lane0_idx");

    wait_to(base+3431);
    player_x = 10'd189; player_y = 10'd165;
    expect_at(base+3433, F_HIT,  COLL, "hit_sticky");
    expect_at(base+3433, F_LANE, 0,    "hit_lane_kept");

    wait_to(base+3434);
    player_x = '0; player_y = '0; hit_clr = 1'b1;
    expect_at(base+3435, F_HIT,  0, "hit_cleared");
    expect_at(base+3435, F_LANE, 0, "hit_lane_after_clr");
    wait_to(base+3435);
    hit_clr = 1'b0;

    wait_to(base+3436);
    player_x = 10'd190; player_y = 10'd165;
    expect_at(base+3437, F_HIT,  COLL,   "hit_lane2");
    expect_at(base+3437, F_LANE, 2*COLL, "hit_lane2_idx");

    // Clear and new overlap in the same cycle: overlap wins.
    wait_to(base+3438);
    player_x = 10'd412; player_y = 10'd245; hit_clr = 1'b1;
    expect_at(base+3439, F_HIT,  COLL,   "clr_vs_ovl_hit");
    expect_at(base+3439, F_LANE, 4*COLL, "clr_vs_ovl_idx");
    expect_at(base+3439, 4, 412,         "l4_pos");
    wait_to(base+3439);
    hit_clr = 1'b0; player_x = '0; player_y = '0;
    expect_at(base+3440, F_HIT, COLL, "hit_before_rst");

    // Reset while hit is set.
    wait_to(base+3440);
    RST_N = 1'b0;
    expect_lanes(base+3441, rst_x, "rst2");
    expect_at(base+3441, F_TICK, 0, "rst2_tick");
    expect_at(base+3441, F_HIT,  0, "rst2_hit");
    expect_at(base+3441, F_LANE, 0, "rst2_hit_lane");
    wait_to(base+3441);
    RST_N = 1'b1;
    expect_at(base+3444, F_TICK, 0, "rst2_tick_low");
    expect_at(base+3445, F_TICK, 1, "rst2_first_tick");

    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations never compared, required 0", q.size());
      errors += q.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
